// File: rtl/enc_pkg.sv
// enc_pkg: shared widths and chunking helpers for the HDC encoder bundler.
package enc_pkg;
    localparam int FEATURE_COUNT_DEF = 617;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int num_chunks(input int fc, input int cw);
        return (fc + cw - 1) / cw;
    endfunction

    // features carried by the final beat; the rest of that beat is padding
    function automatic int tail_bits(input int fc, input int cw);
        return fc - (num_chunks(fc, cw) - 1) * cw;
    endfunction
endpackage

// File: rtl/popcount_tree.sv
// popcount_tree: combinational balanced adder tree counting ones in bits.
module popcount_tree
    import enc_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]        bits,
    output logic [cnt_w(WIDTH)-1:0] cnt
);
    localparam int OW = cnt_w(WIDTH);
    if (WIDTH == 1) begin : g_leaf
        assign cnt = bits;
    end else begin : g_node
        localparam int LO = WIDTH / 2;
        localparam int HI = WIDTH - LO;
        logic [cnt_w(LO)-1:0] lo_cnt;
        logic [cnt_w(HI)-1:0] hi_cnt;
        popcount_tree #(.WIDTH(LO)) u_lo (.bits(bits[LO-1:0]), .cnt(lo_cnt));
        popcount_tree #(.WIDTH(HI)) u_hi (.bits(bits[WIDTH-1:LO]), .cnt(hi_cnt));
        assign cnt = OW'(lo_cnt) + OW'(hi_cnt);
    end
endmodule

// File: rtl/enc_bundler_seq.sv
// enc_bundler_seq: chunked per-lane popcount accumulator with thresholded majority output.
module enc_bundler_seq
    import enc_pkg::*;
#(
    parameter int FEATURE_COUNT = FEATURE_COUNT_DEF,
    parameter int CHUNK_W       = 64,
    parameter int LANES         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic [cnt_w(FEATURE_COUNT)-1:0]     thr,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*CHUNK_W-1:0]            in_bits,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [LANES-1:0]                    out_bits,
    output logic [LANES*cnt_w(FEATURE_COUNT)-1:0] out_sum
);
    localparam int NUM_CHUNKS = num_chunks(FEATURE_COUNT, CHUNK_W);
    localparam int POP_W      = cnt_w(CHUNK_W);
    localparam int ACC_W      = cnt_w(FEATURE_COUNT);
    localparam int CNT_W      = cnt_w(NUM_CHUNKS);
    localparam logic [CHUNK_W-1:0] TAIL_MASK =
        {CHUNK_W{1'b1}} >> (CHUNK_W - tail_bits(FEATURE_COUNT, CHUNK_W));

    logic             stall, accept, first, last, load;
    logic [CNT_W-1:0] chunk_q;
    logic [ACC_W-1:0] thr_q, p_thr;
    logic             p_valid, p_first, p_last;
    logic [POP_W-1:0] pop [LANES];
    logic [POP_W-1:0] pop_q [LANES];
    logic [ACC_W-1:0] acc_q [LANES];
    logic [ACC_W-1:0] acc_d [LANES];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready && !clear;
    assign first    = chunk_q == '0;
    assign last     = chunk_q == CNT_W'(NUM_CHUNKS - 1);
    assign load     = p_valid && p_last && !stall;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CHUNK_W-1:0] bits;
        assign bits = in_bits[l*CHUNK_W +: CHUNK_W] & (last ? TAIL_MASK : {CHUNK_W{1'b1}});
        popcount_tree #(.WIDTH(CHUNK_W)) u_pop (.bits(bits), .cnt(pop[l]));
        assign acc_d[l] = (p_first ? '0 : acc_q[l]) + ACC_W'(pop_q[l]);
    end

    // p_thr travels with each beat so the compare uses the value sampled at chunk 0
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            chunk_q   <= '0;
            p_valid   <= 1'b0;
            out_valid <= 1'b0;
            for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
            if (rst) begin
                thr_q    <= '0;
                out_bits <= '0;
                out_sum  <= '0;
            end
        end else begin
            if (accept) begin
                chunk_q <= last ? '0 : chunk_q + 1'b1;
                if (first) thr_q <= thr;
            end
            if (!stall) begin
                p_valid <= accept;
                p_first <= first;
                p_last  <= last;
                p_thr   <= first ? thr : thr_q;
                for (int l = 0; l < LANES; l++) pop_q[l] <= pop[l];
                if (p_valid) for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
            end
            if (load) begin
                out_valid <= 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    out_sum[l*ACC_W +: ACC_W] <= acc_d[l];
                    out_bits[l]               <= acc_d[l] > p_thr;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_enc_bundler_seq.sv
// tb_enc_bundler_seq: randomized bench with a feature-level counting model and result scoreboard.
module tb_enc_bundler_seq;
    localparam int FC = 617;
    localparam int CW = 64;
    localparam int L  = 4;
    localparam int NC = (FC + CW - 1) / CW;
    localparam int AW = $clog2(FC + 1);

    typedef struct {
        logic [L*CW-1:0] bits;
        logic [AW-1:0]   thr;
        int              chunk;
        logic [L*AW-1:0] esum;
        logic [L-1:0]    ebits;
    } beat_t;

    typedef struct {
        logic [L*AW-1:0] esum;
        logic [L-1:0]    ebits;
        int              cyc;
    } res_t;

    logic            clk = 0, rst, clear, in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0]   thr;
    logic [L*CW-1:0] in_bits;
    logic [L-1:0]    out_bits;
    logic [L*AW-1:0] out_sum;

    beat_t feed[$];
    res_t  sb[$];
    int checks = 0, errors = 0, cyc = 0, n_out = 0, low_cnt = 0;
    int gap_pct = 0, rdy_pct = 100;
    bit lat_chk = 0, rst_now = 1, clr_now = 0, hold = 0;
    logic [L-1:0]    prev_bits;
    logic [L*AW-1:0] prev_sum;

    enc_bundler_seq dut (
        .clk(clk), .rst(rst), .clear(clear), .thr(thr),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // kind 0: random per-lane density, 1: all ones incl. padding, 2: first t_l features set
    task automatic add_vec(input int kind, input int thr0, input int chg, input int thr1,
                           input int t0 = 0, input int t1 = 0, input int t2 = 0, input int t3 = 0);
        logic [L*CW-1:0] b [NC];
        int tg [L];
        int dens [L];
        int s [L];
        beat_t e;
        tg = '{t0, t1, t2, t3};
        for (int l = 0; l < L; l++) begin
            dens[l] = $urandom_range(100);
            s[l] = 0;
        end
        for (int c = 0; c < NC; c++)
            for (int l = 0; l < L; l++)
                for (int k = 0; k < CW; k++)
                    b[c][l*CW+k] = kind == 1 ? 1'b1 :
                                   kind == 2 ? (c*CW + k < tg[l]) : ($urandom_range(99) < dens[l]);
        for (int l = 0; l < L; l++)
            for (int f = 0; f < FC; f++)
                s[l] += int'(b[f/CW][l*CW + f%CW]);
        for (int c = 0; c < NC; c++) begin
            e.bits  = b[c];
            e.thr   = AW'(c >= chg ? thr1 : thr0);
            e.chunk = c;
            for (int l = 0; l < L; l++) begin
                e.esum[l*AW +: AW] = AW'(s[l]);
                e.ebits[l] = s[l] > thr0;
            end
            feed.push_back(e);
        end
    endtask

    task automatic step();
        res_t r;
        @(negedge clk);
        rst       = rst_now;
        clear     = clr_now;
        in_valid  = feed.size() > 0 && ($urandom_range(99) >= gap_pct);
        out_ready = $urandom_range(99) < rdy_pct;
        if (in_valid) begin
            in_bits = feed[0].bits;
            thr     = feed[0].thr;
        end else begin
            for (int i = 0; i < L*CW/32; i++) in_bits[i*32 +: 32] = $urandom();
            thr = AW'($urandom_range(FC));
        end
        #1;
        if (!rst) begin
            chk("in_ready", in_ready, !(out_valid && !out_ready));
            if (!in_ready) low_cnt++;
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_bits", out_bits, prev_bits);
                chk("hold_sum", out_sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    r = sb.pop_front();
                    chk("out_sum", out_sum, r.esum);
                    chk("out_bits", out_bits, r.ebits);
                    if (lat_chk) chk("latency", cyc, r.cyc + 2);
                end
            end
            hold = out_valid && !out_ready;
            prev_bits = out_bits;
            prev_sum  = out_sum;
            if (in_valid && in_ready && !clear) begin
                if (feed[0].chunk == NC - 1) sb.push_back('{feed[0].esum, feed[0].ebits, cyc});
                void'(feed.pop_front());
            end
        end
        if (rst || clear) begin
            sb.delete();
            while (feed.size() > 0 && feed[0].chunk != 0) void'(feed.pop_front());
            hold = 0;
        end
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((feed.size() > 0 || sb.size() > 0) && n < maxc) begin
            step();
            n++;
        end
        repeat (3) step();
        chk("drain", feed.size() + sb.size(), 0);
    endtask

    task automatic wait_head(input int ch, input int maxc);
        int n = 0;
        while (feed.size() > 0 && feed[0].chunk != ch && n < maxc) begin
            step();
            n++;
        end
        chk("reach_chunk", feed.size() > 0 ? feed[0].chunk : -1, ch);
    endtask

    initial begin
        int n0, low0, n;
        rst = 1; clear = 0; in_valid = 0; in_bits = '0; thr = '0; out_ready = 0;
        repeat (3) step();
        rst_now = 0;
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_bits", out_bits, 0);
        chk("rst_sum", out_sum, 0);
        chk("rst_ready", in_ready, 1);

        lat_chk = 1;
        add_vec(1, 308, NC, 0);
        drain(100);
        add_vec(2, 308, NC, 0, 308, 309, 0, 617);
        drain(100);

        n0 = n_out; low0 = low_cnt;
        repeat (3) add_vec(0, $urandom_range(FC), NC, 0);
        drain(200);
        chk("cont_ready_low", low_cnt - low0, 0);
        chk("cont_outs", n_out - n0, 3);
        lat_chk = 0;

        add_vec(0, $urandom_range(FC), NC, 0);
        add_vec(0, $urandom_range(FC), NC, 0);
        rdy_pct = 0; low0 = low_cnt; n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        repeat (5) step();
        chk("stall_low", low_cnt - low0, 6);
        rdy_pct = 100;
        drain(100);

        gap_pct = 30; rdy_pct = 60;
        repeat (6) add_vec(0, $urandom_range(FC), NC, 0);
        drain(1000);
        gap_pct = 0; rdy_pct = 100;

        n0 = n_out;
        add_vec(0, $urandom_range(FC), NC, 0);
        add_vec(0, $urandom_range(FC), NC, 0);
        wait_head(6, 50);
        clr_now = 1;
        step();
        clr_now = 0;
        drain(100);
        chk("clear_outs", n_out - n0, 1);

        add_vec(2, 308, 4, 0, 200, 200, 200, 200);
        drain(100);

        n0 = n_out;
        add_vec(0, $urandom_range(FC), NC, 0);
        wait_head(7, 50);
        rst_now = 1;
        repeat (2) step();
        rst_now = 0;
        step();
        chk("rst2_valid", out_valid, 0);
        chk("rst2_bits", out_bits, 0);
        chk("rst2_sum", out_sum, 0);
        chk("rst2_ready", in_ready, 1);
        repeat (3) step();
        chk("rst2_outs", n_out - n0, 0);
        add_vec(0, $urandom_range(FC), NC, 0);
        drain(100);
        chk("post_rst_outs", n_out - n0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
